// File: rtl/fetch_req_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : fetch_req_ctrl
// Brief   : Pre-IF fetch front end: next-PC generation, single-outstanding
//           SRAM-like instruction reads, redirect cancellation and a
//           registered valid/allowin output stage with a 1-entry skid buffer.
//           Optional macro FETCH_ADEF_EN: misaligned fetch raises ADEF.
// Revision: 1.0 - initial release
// ============================================================================
module fetch_req_ctrl #(
   parameter logic [31:0] RESET_PC  = 32'h1C000000,
   parameter int          EX_CODE_W = 15
) (
   input  logic                          clk,
   input  logic                          resetn,
   output logic                          inst_sram_req,
   output logic                          inst_sram_wr,
   output logic [1:0]                    inst_sram_size,
   output logic [3:0]                    inst_sram_wstrb,
   output logic [31:0]                   inst_sram_addr,
   output logic [31:0]                   inst_sram_wdata,
   input  logic                          inst_sram_addr_ok,
   input  logic                          inst_sram_data_ok,
   input  logic [31:0]                   inst_sram_rdata,
   input  logic                          br_taken,
   input  logic [31:0]                   br_target,
   input  logic                          wb_ex,
   input  logic [31:0]                   ex_entry,
   input  logic                          ertn_flush,
   input  logic [31:0]                   ex_ra,
   input  logic                          ds_allowin,
   output logic                          fs_to_ds_valid,
   output logic [32+32+1+EX_CODE_W-1:0]  fs_to_ds_bus
);

   localparam int BUS_W = 32 + 32 + 1 + EX_CODE_W;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADDR = 2'd1,
      S_DATA = 2'd2
   } state_t;

   state_t             state_q;
   logic               req_q;
   logic [31:0]        addr_q;
   logic [31:0]        last_pc_q;
   logic               redir_pend_q;
   logic [31:0]        redir_pc_q;
   logic               req_redir_q;
   logic               cancel_q;
   logic               out_valid_q;
   logic [BUS_W-1:0]   out_bus_q;
   logic               skid_valid_q;
   logic [BUS_W-1:0]   skid_bus_q;

   logic               redir;
   logic [31:0]        redir_tgt;
   logic [31:0]        fetch_pc_d;
   logic               can_issue;
   logic               consume;
   logic               issue;
   logic               data_acc;
   logic               push;
   logic [BUS_W-1:0]   push_bus;

`ifdef FETCH_ADEF_EN
   localparam logic [EX_CODE_W-1:0] ECODE_ADEF = EX_CODE_W'(6'h08);
   logic               halt_q;
   logic               adef;
`endif

   always_comb begin
      redir      = wb_ex | ertn_flush | br_taken;
      redir_tgt  = br_target;
      if (wb_ex) begin
         redir_tgt = ex_entry;
      end else if (ertn_flush) begin
         redir_tgt = ex_ra;
      end
      fetch_pc_d = redir_pend_q ? redir_pc_q : (last_pc_q + 32'd4);
      can_issue  = !skid_valid_q && (!out_valid_q || ds_allowin);
      consume    = out_valid_q && ds_allowin;
      // A redirect seen in IDLE is latched first and issued next cycle.
`ifdef FETCH_ADEF_EN
      adef       = (state_q == S_IDLE) && can_issue && !redir && !halt_q
                   && (fetch_pc_d[1:0] != 2'b00);
      issue      = (state_q == S_IDLE) && can_issue && !redir && !halt_q && !adef;
`else
      issue      = (state_q == S_IDLE) && can_issue && !redir;
`endif
      data_acc   = (state_q == S_DATA) && inst_sram_data_ok && !cancel_q && !redir;
`ifdef FETCH_ADEF_EN
      push       = data_acc | adef;
      push_bus   = adef ? {fetch_pc_d, 32'd0, 1'b1, ECODE_ADEF}
                        : {addr_q, inst_sram_rdata, 1'b0, {EX_CODE_W{1'b0}}};
`else
      push       = data_acc;
      push_bus   = {addr_q, inst_sram_rdata, 1'b0, {EX_CODE_W{1'b0}}};
`endif
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q      <= S_IDLE;
         req_q        <= 1'b0;
         addr_q       <= RESET_PC;
         last_pc_q    <= RESET_PC - 32'd4;
         redir_pend_q <= 1'b0;
         redir_pc_q   <= 32'd0;
         req_redir_q  <= 1'b0;
         cancel_q     <= 1'b0;
         out_valid_q  <= 1'b0;
         out_bus_q    <= '0;
         skid_valid_q <= 1'b0;
         skid_bus_q   <= '0;
`ifdef FETCH_ADEF_EN
         halt_q       <= 1'b0;
`endif
      end else begin
         if (redir) begin
            redir_pend_q <= 1'b1;
            redir_pc_q   <= redir_tgt;
            req_redir_q  <= 1'b0;
`ifdef FETCH_ADEF_EN
            halt_q       <= 1'b0;
`endif
         end

`ifdef FETCH_ADEF_EN
         if (adef) begin
            redir_pend_q <= 1'b0;
            last_pc_q    <= fetch_pc_d;
            halt_q       <= 1'b1;
         end
`endif

         case (state_q)
            S_IDLE: begin
               if (issue) begin
                  state_q     <= S_ADDR;
                  req_q       <= 1'b1;
                  addr_q      <= fetch_pc_d;
                  last_pc_q   <= fetch_pc_d;
                  req_redir_q <= redir_pend_q;
               end
            end
            S_ADDR: begin
               if (redir) begin
                  cancel_q <= 1'b1;
               end
               if (inst_sram_addr_ok) begin
                  state_q <= S_DATA;
                  req_q   <= 1'b0;
                  // Only the request that carried the target retires the redirect.
                  if (req_redir_q && !redir) begin
                     redir_pend_q <= 1'b0;
                  end
               end
            end
            S_DATA: begin
               if (redir) begin
                  cancel_q <= 1'b1;
               end
               if (inst_sram_data_ok) begin
                  state_q  <= S_IDLE;
                  cancel_q <= 1'b0;
               end
            end
            default: begin
               state_q <= S_IDLE;
               req_q   <= 1'b0;
            end
         endcase

         if (redir) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
         end else if (!out_valid_q || consume) begin
            if (skid_valid_q) begin
               out_valid_q  <= 1'b1;
               out_bus_q    <= skid_bus_q;
               skid_valid_q <= push;
               if (push) begin
                  skid_bus_q <= push_bus;
               end
            end else begin
               out_valid_q <= push;
               if (push) begin
                  out_bus_q <= push_bus;
               end
            end
         end else if (push) begin
            skid_valid_q <= 1'b1;
            skid_bus_q   <= push_bus;
         end
      end
   end

   assign inst_sram_req   = req_q;
   assign inst_sram_wr    = 1'b0;
   assign inst_sram_size  = 2'b10;
   assign inst_sram_wstrb = 4'b0000;
   assign inst_sram_addr  = addr_q;
   assign inst_sram_wdata = 32'd0;
   assign fs_to_ds_valid  = out_valid_q;
   assign fs_to_ds_bus    = out_bus_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_req_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_fetch_req_ctrl
// Brief   : Directed plus randomized bench for fetch_req_ctrl with a
//           transaction-level reference model and a behavioural SRAM slave.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fetch_req_ctrl;

   localparam logic [31:0] RESET_PC  = 32'h1C000000;
   localparam int          EX_CODE_W = 15;
   localparam int          BUS_W     = 32 + 32 + 1 + EX_CODE_W;

   logic              clk;
   logic              resetn;
   logic              inst_sram_req;
   logic              inst_sram_wr;
   logic [1:0]        inst_sram_size;
   logic [3:0]        inst_sram_wstrb;
   logic [31:0]       inst_sram_addr;
   logic [31:0]       inst_sram_wdata;
   logic              inst_sram_addr_ok;
   logic              inst_sram_data_ok;
   logic [31:0]       inst_sram_rdata;
   logic              br_taken;
   logic [31:0]       br_target;
   logic              wb_ex;
   logic [31:0]       ex_entry;
   logic              ertn_flush;
   logic [31:0]       ex_ra;
   logic              ds_allowin;
   logic              fs_to_ds_valid;
   logic [BUS_W-1:0]  fs_to_ds_bus;

   fetch_req_ctrl #(
      .RESET_PC  (RESET_PC),
      .EX_CODE_W (EX_CODE_W)
   ) dut (
      .clk               (clk),
      .resetn            (resetn),
      .inst_sram_req     (inst_sram_req),
      .inst_sram_wr      (inst_sram_wr),
      .inst_sram_size    (inst_sram_size),
      .inst_sram_wstrb   (inst_sram_wstrb),
      .inst_sram_addr    (inst_sram_addr),
      .inst_sram_wdata   (inst_sram_wdata),
      .inst_sram_addr_ok (inst_sram_addr_ok),
      .inst_sram_data_ok (inst_sram_data_ok),
      .inst_sram_rdata   (inst_sram_rdata),
      .br_taken          (br_taken),
      .br_target         (br_target),
      .wb_ex             (wb_ex),
      .ex_entry          (ex_entry),
      .ertn_flush        (ertn_flush),
      .ex_ra             (ex_ra),
      .ds_allowin        (ds_allowin),
      .fs_to_ds_valid    (fs_to_ds_valid),
      .fs_to_ds_bus      (fs_to_ds_bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model state: one request in address phase, one awaiting data,
   // and the ordered list of entries decode must see.
   logic [BUS_W-1:0] m_q[$];
   logic             m_req_act;
   logic [31:0]      m_cur_addr;
   logic             m_cur_cancel;
   int               m_req_wait;
   logic             m_data_pend;
   logic [31:0]      m_pend_addr;
   logic [31:0]      m_pend_data;
   logic             m_pend_cancel;
   int               m_data_wait;
   logic [31:0]      m_exp_next;
   logic             m_prev_block;
   int               m_new_cnt;
   logic [31:0]      m_new_addr;
   int               m_pop_cnt;
   logic [31:0]      m_last_pc;
   logic [31:0]      m_prev_pc;

   int               ao_dly;
   int               do_dly;
   logic [31:0]      next_rdata;

   task automatic chk(input string tag, input logic [BUS_W-1:0] got, input logic [BUS_W-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One bus cycle, called at a negedge: observe outputs, drive inputs,
   // advance the model, then wait for the next negedge.
   task automatic cycle(input logic wb, input logic er, input logic br,
                        input logic [31:0] t_ex, input logic [31:0] t_ra,
                        input logic [31:0] t_br, input logic allow);
      logic             redir;
      logic [31:0]      tgt;
      logic             aok;
      logic             dok;
      logic [BUS_W-1:0] exp;
      redir = wb | er | br;
      tgt   = wb ? t_ex : (er ? t_ra : t_br);
      aok   = 1'b0;
      dok   = 1'b0;
      if (inst_sram_req) begin
         if (!m_req_act) begin
            chk("one_outstanding", BUS_W'(m_data_pend), BUS_W'(0));
            chk("req_gate", BUS_W'(m_prev_block), BUS_W'(0));
            chk("req_addr", BUS_W'(inst_sram_addr), BUS_W'(m_exp_next));
            m_req_act    = 1'b1;
            m_cur_addr   = inst_sram_addr;
            m_cur_cancel = 1'b0;
            m_req_wait   = ao_dly;
            m_exp_next   = inst_sram_addr + 32'd4;
            m_new_cnt++;
            m_new_addr   = inst_sram_addr;
         end else begin
            chk("addr_stable", BUS_W'(inst_sram_addr), BUS_W'(m_cur_addr));
         end
      end else if (m_req_act) begin
         chk("req_held", BUS_W'(inst_sram_req), BUS_W'(1));
      end
      if (m_req_act && inst_sram_req) begin
         if (m_req_wait == 0) aok = 1'b1;
         else m_req_wait--;
      end
      if (m_data_pend) begin
         if (m_data_wait == 0) dok = 1'b1;
         else m_data_wait--;
      end
      inst_sram_addr_ok = aok;
      inst_sram_data_ok = dok;
      inst_sram_rdata   = dok ? m_pend_data : $urandom;
      wb_ex      = wb;
      ertn_flush = er;
      br_taken   = br;
      ex_entry   = t_ex;
      ex_ra      = t_ra;
      br_target  = t_br;
      ds_allowin = allow;
      if (fs_to_ds_valid && allow) begin
         if (m_q.size() == 0) begin
            chk("spurious_valid", BUS_W'(fs_to_ds_valid), BUS_W'(0));
         end else begin
            exp = m_q.pop_front();
            chk("deliver", fs_to_ds_bus, exp);
            m_pop_cnt++;
            m_prev_pc = m_last_pc;
            m_last_pc = fs_to_ds_bus[BUS_W-1 -: 32];
         end
      end
      if (redir && m_req_act)   m_cur_cancel  = 1'b1;
      if (redir && m_data_pend) m_pend_cancel = 1'b1;
      if (dok) begin
         if (!m_pend_cancel) m_q.push_back({m_pend_addr, m_pend_data, 1'b0, {EX_CODE_W{1'b0}}});
         m_data_pend = 1'b0;
      end
      if (aok) begin
         m_req_act     = 1'b0;
         m_data_pend   = 1'b1;
         m_data_wait   = do_dly;
         m_pend_addr   = m_cur_addr;
         m_pend_cancel = m_cur_cancel;
         m_pend_data   = next_rdata;
      end
      if (redir) begin
         m_q.delete();
         m_exp_next = tgt;
      end
      m_prev_block = fs_to_ds_valid && !allow;
      @(negedge clk);
   endtask

   task automatic idle_cycle(input logic allow);
      cycle(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, allow);
   endtask

   task automatic do_reset(input int n);
      resetn            = 1'b0;
      inst_sram_addr_ok = 1'b0;
      inst_sram_data_ok = 1'b0;
      inst_sram_rdata   = 32'd0;
      wb_ex = 1'b0; ertn_flush = 1'b0; br_taken = 1'b0;
      ex_entry = 32'd0; ex_ra = 32'd0; br_target = 32'd0;
      ds_allowin = 1'b0;
      repeat (n) @(negedge clk);
      chk("rst_req", BUS_W'(inst_sram_req), BUS_W'(0));
      chk("rst_valid", BUS_W'(fs_to_ds_valid), BUS_W'(0));
      m_q.delete();
      m_req_act    = 1'b0;
      m_data_pend  = 1'b0;
      m_exp_next   = RESET_PC;
      m_prev_block = 1'b0;
      // Stray data_ok in the release cycle must be ignored.
      resetn            = 1'b1;
      inst_sram_data_ok = 1'b1;
      inst_sram_rdata   = 32'hDEADBEEF;
      ds_allowin        = 1'b1;
      @(negedge clk);
      inst_sram_data_ok = 1'b0;
   endtask

   task automatic wait_new_req(input string tag, input logic [31:0] exp);
      int n0;
      bit seen;
      n0   = m_new_cnt;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         idle_cycle(1'b1);
         if (m_new_cnt != n0) seen = 1'b1;
      end
      chk({tag, "_seen"}, BUS_W'(seen), BUS_W'(1));
      chk(tag, BUS_W'(m_new_addr), BUS_W'(exp));
   endtask

   initial begin
      int n0;
      int p0;
      m_req_act = 1'b0; m_data_pend = 1'b0; m_cur_cancel = 1'b0; m_pend_cancel = 1'b0;
      m_req_wait = 0; m_data_wait = 0; m_new_cnt = 0; m_pop_cnt = 0;
      m_cur_addr = 32'd0; m_pend_addr = 32'd0; m_pend_data = 32'd0; m_new_addr = 32'd0;
      m_last_pc = 32'd0; m_prev_pc = 32'd0; m_prev_block = 1'b0; m_exp_next = RESET_PC;
      ao_dly = 0; do_dly = 0; next_rdata = 32'd0;

      do_reset(3);
      chk("const_wr", BUS_W'(inst_sram_wr), BUS_W'(0));
      chk("const_size", BUS_W'(inst_sram_size), BUS_W'(2));
      chk("const_wstrb", BUS_W'(inst_sram_wstrb), BUS_W'(0));
      chk("const_wdata", BUS_W'(inst_sram_wdata), BUS_W'(0));

      // Basic fetch at minimum latency
      chk("t1_first_req", BUS_W'(inst_sram_req), BUS_W'(1));
      chk("t1_first_addr", BUS_W'(inst_sram_addr), BUS_W'(RESET_PC));
      next_rdata = 32'h02800C0C;
      idle_cycle(1'b1);
      idle_cycle(1'b1);
      chk("t1_valid", BUS_W'(fs_to_ds_valid), BUS_W'(1));
      chk("t1_bus", fs_to_ds_bus, {32'h1C000000, 32'h02800C0C, 1'b0, {EX_CODE_W{1'b0}}});
      idle_cycle(1'b1);
      chk("t1_next_req", BUS_W'(inst_sram_req), BUS_W'(1));
      chk("t1_next_addr", BUS_W'(inst_sram_addr), BUS_W'(32'h1C000004));

      // Branch redirect while waiting for data of 0x1C000008
      do_dly = 3;
      for (int i = 0; i < 40 && !(m_data_pend && m_pend_addr == 32'h1C000008); i++)
         idle_cycle(1'b1);
      chk("t2_reach", BUS_W'(m_data_pend && m_pend_addr == 32'h1C000008), BUS_W'(1));
      cycle(1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 32'h1C000100, 1'b1);
      wait_new_req("t2_br_tgt", 32'h1C000100);

      // Exception beats branch in the same cycle
      do_dly = 0;
      cycle(1'b1, 1'b0, 1'b1, 32'h1C008000, 32'd0, 32'h1C000200, 1'b1);
      wait_new_req("t3_prio", 32'h1C008000);

      // Decode stalls for five cycles
      n0 = m_new_cnt;
      repeat (5) idle_cycle(1'b0);
      chk("t4_hold_valid", BUS_W'(fs_to_ds_valid), BUS_W'(1));
      chk("t4_hold_pc", BUS_W'(fs_to_ds_bus[BUS_W-1 -: 32]), BUS_W'(32'h1C008000));
      chk("t4_no_req", BUS_W'(m_new_cnt), BUS_W'(n0));
      p0 = m_pop_cnt;
      repeat (15) idle_cycle(1'b1);
      chk("t4_drained", BUS_W'(m_pop_cnt - p0 >= 2), BUS_W'(1));
      chk("t4_pc_step", BUS_W'(m_last_pc - m_prev_pc), BUS_W'(4));

      // Redirect during a slow address phase
      ao_dly = 3;
      for (int i = 0; i < 40 && !(m_req_act && m_req_wait >= 1); i++)
         idle_cycle(1'b1);
      chk("t5_in_addr", BUS_W'(m_req_act && m_req_wait >= 1), BUS_W'(1));
      cycle(1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 32'h1C000300, 1'b1);
      ao_dly = 0;
      wait_new_req("t5_br_tgt", 32'h1C000300);

      // Reset in the middle of a transaction
      do_dly = 3;
      for (int i = 0; i < 40 && !m_data_pend; i++) idle_cycle(1'b1);
      do_reset(2);
      chk("t6_first_req", BUS_W'(inst_sram_req), BUS_W'(1));
      chk("t6_first_addr", BUS_W'(inst_sram_addr), BUS_W'(RESET_PC));

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         logic [2:0]  kind;
         logic [31:0] t1;
         logic [31:0] t2;
         logic [31:0] t3;
         ao_dly     = $urandom_range(0, 3);
         do_dly     = $urandom_range(0, 3);
         next_rdata = $urandom;
         kind = ($urandom_range(0, 99) < 6) ? 3'($urandom_range(1, 7)) : 3'd0;
         t1 = $urandom & 32'hFFFFFFFC;
         t2 = $urandom & 32'hFFFFFFFC;
         t3 = ($urandom_range(0, 9) == 0) ? 32'hFFFFFFF8 : ($urandom & 32'hFFFFFFFC);
         cycle(kind[2], kind[1], kind[0], t1, t2, t3, $urandom_range(0, 3) != 0);
      end
      chk("rand_traffic", BUS_W'(m_pop_cnt > 200), BUS_W'(1));

`ifdef FETCH_ADEF_EN
      ao_dly = 0;
      do_dly = 0;
      cycle(1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 32'h1C000102, 1'b0);
      for (int i = 0; i < 20 && !fs_to_ds_valid; i++) idle_cycle(1'b0);
      chk("adef_bus", fs_to_ds_bus, {32'h1C000102, 32'd0, 1'b1, 15'h0008});
      n0 = m_new_cnt;
      repeat (6) idle_cycle(1'b0);
      chk("adef_no_req", BUS_W'(m_new_cnt), BUS_W'(n0));
      cycle(1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 32'h1C000400, 1'b0);
      wait_new_req("adef_resume", 32'h1C000400);
`endif

      // Drain: hold off new address phases and require everything delivered
      ao_dly = 100000;
      repeat (20) idle_cycle(1'b1);
      chk("drain_empty", BUS_W'(m_q.size()), BUS_W'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fetch_req_ctrl.md
Name: fetch_req_ctrl

Overview:
- Pre-IF fetch front end for the 5-stage LoongArch pipeline.
- Generates the next fetch PC and issues instruction reads on a req/addr_ok/data_ok SRAM-like bus, at most one request outstanding.
- Cancels stale responses after a branch, exception or ertn redirect.
- Delivers {pc, inst, ex, ecode} to the decode stage through a registered valid/allowin handshake with a 1-entry skid buffer.

Parameters:
- RESET_PC, 32'h1C000000, address of the first fetch after reset.
- EX_CODE_W, 15, width of the exception code field forwarded to decode.

Ports:
- clk  in  1  clock.
- resetn  in  1  reset, synchronous, active-low.
- inst_sram_req  out  1  request valid.
- inst_sram_wr  out  1  constant 0.
- inst_sram_size  out  2  constant 2'b10 (word).
- inst_sram_wstrb  out  4  constant 0.
- inst_sram_addr  out  32  fetch address.
- inst_sram_wdata  out  32  constant 0.
- inst_sram_addr_ok  in  1  request accepted this cycle.
- inst_sram_data_ok  in  1  read data valid this cycle.
- inst_sram_rdata  in  32  read data.
- br_taken  in  1  branch redirect pulse from decode.
- br_target  in  32  branch target.
- wb_ex  in  1  exception redirect pulse from writeback.
- ex_entry  in  32  exception entry.
- ertn_flush  in  1  ertn redirect pulse.
- ex_ra  in  32  ertn return address.
- ds_allowin  in  1  decode can accept.
- fs_to_ds_valid  out  1  output entry valid.
- fs_to_ds_bus  out  32+32+1+EX_CODE_W  {pc, inst, ex, ecode}.

Behaviour:
- Redirect priority: wb_ex > ertn_flush > br_taken. Any redirect is a pulse. Its target is latched into redir_pc and redir_pend is set, then held until a request carrying that target gets addr_ok.
- A redirect also clears the output register and the skid buffer in the same edge. fs_to_ds_valid=0 next cycle.
- FSM states:
  - IDLE: drive req when can_issue.
  - ADDR: req=1, addr held stable until addr_ok.
  - DATA: wait for data_ok.
- Transitions:
  - IDLE→ADDR when can_issue. can_issue = skid empty AND (out empty OR ds_allowin).
  - ADDR→DATA on addr_ok.
  - DATA→IDLE on data_ok.
  - IDLE with addr_ok and data_ok in the same cycle is not legal. data_ok arrives ≥1 cycle after addr_ok.
- Request address: redir_pend ? redir_pc : seq_pc. seq_pc = last issued pc + 4, modulo 2^32 (wraps at 32'hFFFFFFFC→0).
- Redirect while in ADDR: addr and req must not change. The request completes and is marked cancel=1.
- Redirect while in DATA: set cancel=1.
- When data_ok arrives with cancel=1, the response is dropped and cancel is cleared. The redirect target is issued from IDLE in the following cycle.
- Redirect and data_ok in the same cycle: the response is dropped.
- Accepted data_ok (cancel=0) is written to the output register if out is empty or ds_allowin=1; otherwise it goes to the skid buffer.
- When out is consumed and the skid is full, the skid moves into out at the same edge.
- fs_to_ds_valid is registered. Minimum latency is addr_ok cycle → data_ok cycle → valid the next cycle.
- Reset values:
  - req=0, state=IDLE, redir_pend=0, cancel=0, out and skid empty, fs_to_ds_valid=0.
  - Internal last-pc = RESET_PC-4, so the first request addr = RESET_PC.
  - First req is asserted the cycle after resetn rises.
- resetn low mid-transaction: all state is cleared. A later data_ok while in IDLE after reset is ignored.

Optional Feature:
- FETCH_ADEF_EN defined:
  - If the request address has [1:0]≠0, no bus request is issued.
  - An entry {pc, inst=0, ex=1, ecode=ADEF (6'h08 in bits [5:0], rest 0)} enters the output path directly.
  - Fetching then stops until a redirect arrives.
- Undefined: ex=0, ecode=0 always, and the address is issued unchanged.

Test Plan:
- Reset, then addr_ok at the 1st req cycle and data_ok 1 cycle later with rdata=32'h02800C0C → fs_to_ds_bus pc=32'h1C000000, inst=32'h02800C0C, valid the following cycle; next req addr=32'h1C000004.
- br_taken=1, br_target=32'h1C000100 while in DATA for pc 32'h1C000008 → that response is dropped (no valid); next req addr=32'h1C000100.
- wb_ex=1 (ex_entry=32'h1C008000) and br_taken=1 (br_target=32'h1C000200) in the same cycle → next issued addr=32'h1C008000.
- ds_allowin=0 for 5 cycles with two responses arriving → out holds the first, skid holds the second, no new req; on ds_allowin=1 the entries drain in order with pcs +4 apart.
- Redirect while in ADDR with addr_ok delayed 3 cycles → addr stays stable until addr_ok; that data is dropped; target issued afterwards.
- FETCH_ADEF_EN defined, br_target=32'h1C000102 → no req; output ex=1, ecode=15'h0008, pc=32'h1C000102.
